// File: rtl/fio_mem_host_xfer.sv
// fio_mem_host_xfer: host-side initiator for the data-memory FIO port (port B).
// LOAD packs eight 32-bit host words into one 256-bit line and writes it.
// DUMP reads one 256-bit line and streams it out as eight 32-bit host words.
// Word k of the stream maps to line bits [32k+31:32k] (BRAM lane k).
module fio_mem_host_xfer #(
    parameter int  mem_size   = 256,
    parameter int  shmem_size = 256,
    localparam int addr_width = $clog2(mem_size + shmem_size)
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [addr_width-1:0] cmd_base,
    input  logic [addr_width:0]   cmd_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  FIO_MEMWRITE,
    output logic [addr_width-1:0] FIO_ADDR,
    output logic [255:0]          FIO_WRITE_DATA,
    input  logic [255:0]          FIO_READ_DATA
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_FILL, S_LD_WRITE, S_RD_ADDR, S_RD_CAP, S_RD_SEND, S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [addr_width-1:0] r_addr;
    logic [addr_width:0]   r_left;
    logic [2:0]            r_idx;
    logic [31:0]           r_buf [8];

    logic                  r_fio_we;
    logic [addr_width-1:0] r_fio_addr;
    logic [255:0]          r_fio_wdata;
    logic                  r_done;

    logic                  w_cmd_acc;
    logic                  w_in_acc;
    logic                  w_out_acc;
    logic                  w_last_word;
    logic                  w_last_line;

    assign w_cmd_acc   = cmd_valid && cmd_ready;
    assign w_in_acc    = in_valid && in_ready;
    assign w_out_acc   = out_valid && out_ready;
    assign w_last_word = (r_idx == 3'd7);
    assign w_last_line = (r_left == {{addr_width{1'b0}}, 1'b1});

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_cmd_acc) begin
                    if (cmd_count == '0) begin
                        w_state_nxt = S_FIN;
                    end else if (cmd_op) begin
                        w_state_nxt = S_RD_ADDR;
                    end else begin
                        w_state_nxt = S_LD_FILL;
                    end
                end
            end
            S_LD_FILL: begin
                in_ready = 1'b1;
                if (w_in_acc && w_last_word) begin
                    w_state_nxt = S_LD_WRITE;
                end
            end
            S_LD_WRITE: begin
                w_state_nxt = w_last_line ? S_FIN : S_LD_FILL;
            end
            S_RD_ADDR: begin
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_state_nxt = S_RD_SEND;
            end
            S_RD_SEND: begin
                out_valid = 1'b1;
                if (w_out_acc && w_last_word) begin
                    w_state_nxt = w_last_line ? S_FIN : S_RD_ADDR;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign out_last = out_valid && w_last_word && w_last_line;
    assign out_data = out_valid ? r_buf[r_idx] : 32'd0;

    // Line address, remaining-line counter and word index.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_addr <= '0;
            r_left <= '0;
            r_idx  <= '0;
        end else begin
            if (w_cmd_acc) begin
                r_addr <= cmd_base;
                r_left <= cmd_count;
                r_idx  <= '0;
            end
            if (w_in_acc || w_out_acc) begin
                r_idx <= r_idx + 3'd1;
            end
            if ((r_state == S_LD_WRITE) || (w_out_acc && w_last_word)) begin
                r_addr <= r_addr + 1'b1;
                r_left <= r_left - 1'b1;
            end
        end
    end

    // Line buffer: host words fill it on LOAD, the read line lands in it on DUMP.
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_buf[r_idx] <= in_data;
        end
        if (r_state == S_RD_CAP) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[k] <= FIO_READ_DATA[32*k +: 32];
            end
        end
    end

    // Registered FIO port and done pulse; set up one cycle ahead of the state they belong to.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_fio_we    <= 1'b0;
            r_fio_addr  <= '0;
            r_fio_wdata <= '0;
            r_done      <= 1'b0;
        end else begin
            r_fio_we <= 1'b0;
            r_done   <= (w_state_nxt == S_FIN);
            if (w_in_acc && w_last_word) begin
                r_fio_we   <= 1'b1;
                r_fio_addr <= r_addr;
                for (int k = 0; k < 7; k++) begin
                    r_fio_wdata[32*k +: 32] <= r_buf[k];
                end
                r_fio_wdata[255:224] <= in_data;
            end
            if (w_state_nxt == S_RD_ADDR) begin
                r_fio_addr <= (r_state == S_IDLE) ? cmd_base : r_addr + 1'b1;
            end
        end
    end

    assign FIO_MEMWRITE   = r_fio_we;
    assign FIO_ADDR       = r_fio_addr;
    assign FIO_WRITE_DATA = r_fio_wdata;
    assign done           = r_done;

endmodule

// File: tb/tb_fio_mem_host_xfer.sv
// Directed bench for fio_mem_host_xfer with a 1-cycle-latency port-B memory model.
`timescale 1ns/1ps
module tb_fio_mem_host_xfer;

    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_op = 1'b0;
    logic [8:0]   cmd_base = '0;
    logic [9:0]   cmd_count = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         FIO_MEMWRITE;
    logic [8:0]   FIO_ADDR;
    logic [255:0] FIO_WRITE_DATA;
    logic [255:0] rd_q;

    logic [255:0] mem [512];
    logic         pl_en = 1'b0;
    logic [8:0]   pl_addr = '0;
    logic [255:0] pl_data = '0;
    int           wr_cnt = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    fio_mem_host_xfer dut (
        .clk(clk), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done),
        .FIO_MEMWRITE(FIO_MEMWRITE), .FIO_ADDR(FIO_ADDR),
        .FIO_WRITE_DATA(FIO_WRITE_DATA), .FIO_READ_DATA(rd_q)
    );

    always #5 clk = ~clk;

    // Port-B BRAM: synchronous write, 1-cycle read latency, no output register.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (FIO_MEMWRITE) mem[FIO_ADDR] <= FIO_WRITE_DATA;
        rd_q <= mem[FIO_ADDR];
    end

    always @(negedge clk) if (FIO_MEMWRITE === 1'b1) wr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [8:0] a, input logic [255:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out: got v=%b l=%b want 0 0", out_valid, out_last); end
        n_chk++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_chk++; if (FIO_MEMWRITE !== 1'b0 || FIO_ADDR !== 9'd0) begin n_fail++; $display("FAIL rst_fio: got we=%b a=%h want 0 0", FIO_MEMWRITE, FIO_ADDR); end
        n_chk++; if (FIO_WRITE_DATA !== 256'd0) begin n_fail++; $display("FAIL rst_fio_wdata: got %h want 0", FIO_WRITE_DATA); end
        resetb = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_single_load();
        logic [255:0] exp;
        int w0;
        w0 = wr_cnt;
        for (int k = 0; k < 8; k++) exp[32*k +: 32] = 32'h1000_0000 + 32'(k);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 9'h010; cmd_count = 10'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sl_fill_entry: got busy=%b in_ready=%b want 1 1", busy, in_ready); end
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (FIO_MEMWRITE !== 1'b0) begin n_fail++; $display("FAIL sl_early_write: got %b want 0 before word %0d", FIO_MEMWRITE, k); end
            in_valid = 1'b1; in_data = 32'h1000_0000 + 32'(k);
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        n_chk++; if (FIO_MEMWRITE !== 1'b1) begin n_fail++; $display("FAIL sl_write_pulse: got %b want 1", FIO_MEMWRITE); end
        n_chk++; if (FIO_ADDR !== 9'h010) begin n_fail++; $display("FAIL sl_addr: got %h want 010", FIO_ADDR); end
        n_chk++; if (FIO_WRITE_DATA !== exp) begin n_fail++; $display("FAIL sl_wdata: got %h want %h", FIO_WRITE_DATA, exp); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sl_in_ready_write: got %b want 0", in_ready); end
        @(negedge clk);
        n_chk++; if (done !== 1'b1 || FIO_MEMWRITE !== 1'b0) begin n_fail++; $display("FAIL sl_done: got done=%b we=%b want 1 0", done, FIO_MEMWRITE); end
        n_chk++; if (wr_cnt !== w0 + 1) begin n_fail++; $display("FAIL sl_wr_count: got %0d want %0d", wr_cnt, w0 + 1); end
        n_chk++; if (mem[9'h010] !== exp) begin n_fail++; $display("FAIL sl_mem: got %h want %h", mem[9'h010], exp); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sl_idle: got done=%b ready=%b want 0 1", done, cmd_ready); end
    endtask

    task automatic test_load_wrap();
        logic [255:0] exp0, exp1, exp;
        logic         rdy;
        int           sent, guard;
        for (int k = 0; k < 8; k++) begin
            exp0[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
            exp1[32*k +: 32] = 32'h5A5A_0000 + 32'(k);
        end
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 9'h1FF; cmd_count = 10'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int ln = 0; ln < 2; ln++) begin
            sent = 0; guard = 0;
            while (sent < 8 && guard < 200) begin
                n_chk++; if (FIO_MEMWRITE !== 1'b0) begin n_fail++; $display("FAIL lw_early_write: got %b want 0 line %0d word %0d", FIO_MEMWRITE, ln, sent); end
                rdy = in_ready;
                in_valid = ($urandom_range(0, 2) != 0);
                in_data = !in_valid ? 32'hDEAD_BEEF : (ln == 0 ? 32'hA5A5_0000 : 32'h5A5A_0000) + 32'(sent);
                @(negedge clk);
                guard++;
                if (rdy && in_valid) sent++;
            end
            in_valid = 1'b0;
            n_chk++; if (sent != 8) begin n_fail++; $display("FAIL lw_timeout: got %0d words want 8", sent); end
            exp = (ln == 0) ? exp0 : exp1;
            n_chk++; if (FIO_MEMWRITE !== 1'b1) begin n_fail++; $display("FAIL lw_write_pulse: got %b want 1 line %0d", FIO_MEMWRITE, ln); end
            n_chk++; if (FIO_ADDR !== (ln == 0 ? 9'h1FF : 9'h000)) begin n_fail++; $display("FAIL lw_addr: got %h want %h", FIO_ADDR, (ln == 0 ? 9'h1FF : 9'h000)); end
            n_chk++; if (FIO_WRITE_DATA !== exp) begin n_fail++; $display("FAIL lw_wdata: got %h want %h", FIO_WRITE_DATA, exp); end
            @(negedge clk);
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b want 1", done); end
        n_chk++; if (mem[9'h1FF] !== exp0 || mem[9'h000] !== exp1) begin n_fail++; $display("FAIL lw_mem: got %h / %h", mem[9'h1FF], mem[9'h000]); end
        @(negedge clk);
    endtask

    task automatic test_dump();
        logic [255:0] l0, l1;
        logic [31:0]  exp_w, held_d;
        logic         held_l, stalled, vld_s;
        int           got, guard;
        for (int k = 0; k < 8; k++) begin
            l0[32*k +: 32] = 32'h2020_0000 + 32'(k);
            l1[32*k +: 32] = 32'h2021_0000 + 32'(k);
        end
        preload(9'h020, l0);
        preload(9'h021, l1);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 9'h020; cmd_count = 10'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (FIO_ADDR !== 9'h020 || FIO_MEMWRITE !== 1'b0) begin n_fail++; $display("FAIL dp_rd_addr: got a=%h we=%b want 020 0", FIO_ADDR, FIO_MEMWRITE); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dp_valid_addr: got %b want 0", out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dp_valid_cap: got %b want 0", out_valid); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dp_first_latency: got %b want 1", out_valid); end
        got = 0; guard = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        while (got < 16 && guard < 400) begin
            if (out_valid) begin
                exp_w = (got < 8 ? 32'h2020_0000 : 32'h2021_0000) + 32'(got % 8);
                n_chk++; if (out_data !== exp_w) begin n_fail++; $display("FAIL dp_data: got %h want %h word %0d", out_data, exp_w, got); end
                n_chk++; if (out_last !== (got == 15)) begin n_fail++; $display("FAIL dp_last: got %b want %b word %0d", out_last, (got == 15), got); end
                if (stalled) begin
                    n_chk++; if (out_data !== held_d || out_last !== held_l) begin n_fail++; $display("FAIL dp_stall_hold: got %h/%b want %h/%b", out_data, out_last, held_d, held_l); end
                end
            end else begin
                n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL dp_last_idle: got %b want 0", out_last); end
            end
            vld_s = out_valid;
            out_ready = ((guard % 3) != 0);
            stalled = out_valid && !out_ready;
            held_d = out_data; held_l = out_last;
            @(negedge clk);
            guard++;
            if (vld_s && out_ready) got++;
        end
        out_ready = 1'b0;
        n_chk++; if (got != 16) begin n_fail++; $display("FAIL dp_count: got %0d words want 16", got); end
        n_chk++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL dp_done: got done=%b valid=%b want 1 0", done, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = wr_cnt;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 9'h0AB; cmd_count = 10'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_chk++; if (busy !== 1'b1 || done !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL zc_fin: got busy=%b done=%b ready=%b want 1 1 0", busy, done, cmd_ready); end
        n_chk++; if (FIO_MEMWRITE !== 1'b0 || FIO_ADDR !== 9'h021) begin n_fail++; $display("FAIL zc_fio: got we=%b a=%h want 0 021", FIO_MEMWRITE, FIO_ADDR); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zc_idle: got busy=%b done=%b ready=%b want 0 0 1", busy, done, cmd_ready); end
        n_chk++; if (wr_cnt !== w0 || FIO_ADDR !== 9'h021) begin n_fail++; $display("FAIL zc_no_activity: got writes=%0d a=%h want %0d 021", wr_cnt, FIO_ADDR, w0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 9'h030; cmd_count = 10'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 32'h3000_0000 + 32'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 9'h030; cmd_count = 10'd1; out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            exp_w = 32'h3000_0000 + 32'(k);
            n_chk++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_fail++; $display("FAIL bb_word: got v=%b %h want 1 %h word %0d", out_valid, out_data, exp_w, k); end
            n_chk++; if (out_last !== (k == 7)) begin n_fail++; $display("FAIL bb_last: got %b want %b word %0d", out_last, (k == 7), k); end
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL bb_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [255:0] orig;
        int w0;
        orig = {8{32'h5555_AAAA}};
        preload(9'h055, orig);
        w0 = wr_cnt;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 9'h055; cmd_count = 10'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h7700_0000 + 32'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        resetb = 1'b0;
        #1;
        n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ab_rst_ctrl: got ready=%b busy=%b in_ready=%b want 1 0 0", cmd_ready, busy, in_ready); end
        n_chk++; if (FIO_MEMWRITE !== 1'b0 || FIO_ADDR !== 9'd0 || FIO_WRITE_DATA !== 256'd0) begin n_fail++; $display("FAIL ab_rst_fio: got we=%b a=%h", FIO_MEMWRITE, FIO_ADDR); end
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ab_release_ready: got %b want 1", cmd_ready); end
        in_valid = 1'b1; in_data = 32'h7700_0005;
        repeat (10) begin
            @(negedge clk);
            in_data = in_data + 32'd1;
        end
        in_valid = 1'b0;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ab_in_ready: got %b want 0", in_ready); end
        n_chk++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL ab_no_write: got %0d writes want %0d", wr_cnt, w0); end
        n_chk++; if (mem[9'h055] !== orig) begin n_fail++; $display("FAIL ab_mem: got %h want %h", mem[9'h055], orig); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_load_wrap();
        test_dump();
        test_zero_count();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
